// File: rtl/fft_pkg.sv
// Shared types and address helpers for the radix-2 DIT FFT address generator.
// Helpers work at the widest legal size; callers truncate to their LOG2N.
package fft_pkg;

   localparam int LOG2N_MIN    = 2;
   localparam int LOG2N_MAX    = 10;
   localparam int PIPE_LAT_MIN = 1;
   localparam int PIPE_LAT_MAX = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } agu_state_e;

   typedef logic [LOG2N_MAX-1:0] addr_max_t;

   function automatic addr_max_t span_mask(input int s);
      return addr_max_t'((1 << s) - 1);
   endfunction

   // j with a zero bit inserted at position s
   function automatic addr_max_t bfly_addr_a(input addr_max_t j,
                                             input int s);
      return ((j >> s) << (s + 1)) | (j & span_mask(s));
   endfunction

   function automatic addr_max_t bfly_addr_b(input addr_max_t a,
                                             input int s);
      return a | (addr_max_t'(1) << s);
   endfunction

   function automatic addr_max_t tw_addr_of(input addr_max_t j,
                                            input int s,
                                            input int log2n);
      return (j & span_mask(s)) << (log2n - 1 - s);
   endfunction

endpackage

// File: rtl/agu_delay_line.sv
// Fixed-depth shift register carrying read-side info to the write side.
// Shifts every cycle; reset clears every entry, including the valid bit.
module agu_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe_q [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_agu_gen.sv
// In-place radix-2 DIT FFT address generator: read/twiddle addresses,
// bank select, stage sequencing and delayed write addresses.
module fft_agu_gen #(
   parameter int LOG2N    = 6,
   parameter int PIPE_LAT = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     stall,
   output logic [LOG2N-1:0]         addr_a,
   output logic [LOG2N-1:0]         addr_b,
   output logic [LOG2N-2:0]         tw_addr,
   output logic                     rd_valid,
   output logic                     read_sel,
   output logic [LOG2N-1:0]         wr_addr_a,
   output logic [LOG2N-1:0]         wr_addr_b,
   output logic                     wr_en,
   output logic [$clog2(LOG2N)-1:0] stage,
   output logic                     busy,
   output logic                     done
);

   import fft_pkg::*;

   localparam int JW = LOG2N - 1;
   localparam int SW = $clog2(LOG2N);
   localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam int PW = 1 + 2 * LOG2N;

   localparam logic [JW-1:0] J_LAST = {JW{1'b1}};
   localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
   localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

   agu_state_e    state_q, state_n;
   logic [JW-1:0] j_q, j_n;
   logic [SW-1:0] stage_q, stage_n;
   logic [DW-1:0] dcnt_q, dcnt_n;
   logic          sel_q, sel_n;
   logic          done_q, done_n;
   logic          issue;
   logic          running;

   logic [LOG2N-1:0] a_w, b_w;
   logic [JW-1:0]    tw_w;
   logic [PW-1:0]    pipe_in, pipe_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         j_q     <= '0;
         stage_q <= '0;
         dcnt_q  <= '0;
         sel_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         j_q     <= j_n;
         stage_q <= stage_n;
         dcnt_q  <= dcnt_n;
         sel_q   <= sel_n;
         done_q  <= done_n;
      end
   end

   always_comb begin
      state_n = state_q;
      j_n     = j_q;
      stage_n = stage_q;
      dcnt_n  = '0;
      sel_n   = sel_q;
      done_n  = 1'b0;
      issue   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_n = RUN;
               j_n     = '0;
               stage_n = '0;
            end
         end
         RUN: begin
            if (!stall) begin
               issue = 1'b1;
               if (j_q == J_LAST) begin
                  state_n = DRAIN;
                  j_n     = '0;
               end else begin
                  j_n = j_q + JW'(1);
               end
            end
         end
         DRAIN: begin
            dcnt_n = dcnt_q + DW'(1);
            // last write of the stage lands in this final drain cycle
            if (dcnt_q == D_LAST) begin
               dcnt_n = '0;
               if (stage_q == S_LAST) begin
                  state_n = IDLE;
                  stage_n = '0;
                  done_n  = 1'b1;
               end else begin
                  state_n = RUN;
                  stage_n = stage_q + SW'(1);
                  sel_n   = ~sel_q;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign running = (state_q == RUN);

   assign a_w  = LOG2N'(bfly_addr_a(addr_max_t'(j_q), int'(stage_q)));
   assign b_w  = LOG2N'(bfly_addr_b(addr_max_t'(a_w), int'(stage_q)));
   assign tw_w = JW'(tw_addr_of(addr_max_t'(j_q), int'(stage_q), LOG2N));

   assign addr_a   = running ? a_w : '0;
   assign addr_b   = running ? b_w : '0;
   assign tw_addr  = running ? tw_w : '0;
   assign rd_valid = issue;
   assign read_sel = sel_q;
   assign stage    = stage_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;

   assign pipe_in = {issue, addr_a, addr_b};

   agu_delay_line #(
      .WIDTH (PW),
      .DEPTH (PIPE_LAT)
   ) u_wr_pipe (
      .clk   (clk),
      .reset (reset),
      .din   (pipe_in),
      .dout  (pipe_out)
   );

   assign wr_en     = pipe_out[PW-1];
   assign wr_addr_a = pipe_out[2*LOG2N-1:LOG2N];
   assign wr_addr_b = pipe_out[LOG2N-1:0];

endmodule

// File: tb/tb_fft_agu_gen.sv
// Scoreboard bench for fft_agu_gen: N=8/PIPE_LAT=2 directed runs plus
// a default-size latency and read-count run.
module tb_fft_agu_gen;

   localparam int P = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;
   logic start = 1'b0;
   logic stall = 1'b0;
   logic [2:0] addr_a, addr_b, wr_addr_a, wr_addr_b;
   logic [1:0] tw_addr, stage;
   logic rd_valid, read_sel, wr_en, busy, done;

   logic start6 = 1'b0;
   logic stall6 = 1'b0;
   logic [5:0] addr_a6, addr_b6, wr_addr_a6, wr_addr_b6;
   logic [4:0] tw_addr6;
   logic [2:0] stage6;
   logic rd_valid6, read_sel6, wr_en6, busy6, done6;

   fft_agu_gen #(.LOG2N(3), .PIPE_LAT(2)) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall),
      .addr_a(addr_a), .addr_b(addr_b), .tw_addr(tw_addr),
      .rd_valid(rd_valid), .read_sel(read_sel),
      .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .wr_en(wr_en),
      .stage(stage), .busy(busy), .done(done)
   );

   fft_agu_gen dut6 (
      .clk(clk), .reset(reset), .start(start6), .stall(stall6),
      .addr_a(addr_a6), .addr_b(addr_b6), .tw_addr(tw_addr6),
      .rd_valid(rd_valid6), .read_sel(read_sel6),
      .wr_addr_a(wr_addr_a6), .wr_addr_b(wr_addr_b6), .wr_en(wr_en6),
      .stage(stage6), .busy(busy6), .done(done6)
   );

   typedef struct {
      int cyc; int a; int b; int tw; int sel; int stg;
   } rd_t;
   typedef struct {
      int cyc; int a; int b;
   } wr_t;

   rd_t rq[$];
   wr_t wq[$];
   wr_t hq[$];
   int  dq[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   int n6_rd = 0;
   int n6_done = 0;
   int d6_cyc = -1;

   // hand-computed N=8 butterflies, stage-major order
   int ta[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int tb_[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int tt[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
   int rc_ns[12] = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};
   int rc_st[12] = '{1, 4, 5, 6, 9, 11, 12, 13, 16, 19, 20, 21};
   int sl[11] = '{2, 3, 7, 8, 10, 14, 15, 17, 18, 22, 23};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int want);
      n_cmp++;
      if (act != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  nm, act, want, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (rd_valid) begin
            if (rq.size() == 0) begin
               chk("unexpected_rd", int'(rd_valid), 0);
            end else begin
               rd_t e;
               e = rq.pop_front();
               chk("rd_cycle", cyc, e.cyc);
               chk("rd_addr_a", int'(addr_a), e.a);
               chk("rd_addr_b", int'(addr_b), e.b);
               chk("rd_tw", int'(tw_addr), e.tw);
               chk("rd_sel", int'(read_sel), e.sel);
               chk("rd_stage", int'(stage), e.stg);
               chk("rd_busy", int'(busy), 1);
            end
         end
         if (wr_en) begin
            if (wq.size() == 0) begin
               chk("unexpected_wr", int'(wr_en), 0);
            end else begin
               wr_t w;
               w = wq.pop_front();
               chk("wr_cycle", cyc, w.cyc);
               chk("wr_addr_a", int'(wr_addr_a), w.a);
               chk("wr_addr_b", int'(wr_addr_b), w.b);
            end
         end
         if (done) begin
            if (dq.size() == 0) begin
               chk("unexpected_done", int'(done), 0);
            end else begin
               chk("done_cycle", cyc, dq.pop_front());
               chk("busy_at_done", int'(busy), 0);
            end
         end
         if (hq.size() > 0 && hq[0].cyc == cyc) begin
            wr_t h;
            h = hq.pop_front();
            chk("hold_addr_a", int'(addr_a), h.a);
            chk("hold_addr_b", int'(addr_b), h.b);
            chk("hold_rd_valid", int'(rd_valid), 0);
         end
         if (rd_valid6) n6_rd++;
         if (done6) begin
            n6_done++;
            d6_cyc = cyc;
         end
      end
   end

   task automatic check_idle(input string nm);
      chk({nm, "_addr_a"}, int'(addr_a), 0);
      chk({nm, "_addr_b"}, int'(addr_b), 0);
      chk({nm, "_tw"}, int'(tw_addr), 0);
      chk({nm, "_rd_valid"}, int'(rd_valid), 0);
      chk({nm, "_read_sel"}, int'(read_sel), 0);
      chk({nm, "_wr_addr_a"}, int'(wr_addr_a), 0);
      chk({nm, "_wr_addr_b"}, int'(wr_addr_b), 0);
      chk({nm, "_wr_en"}, int'(wr_en), 0);
      chk({nm, "_stage"}, int'(stage), 0);
      chk({nm, "_busy"}, int'(busy), 0);
      chk({nm, "_done"}, int'(done), 0);
   endtask

   task automatic push_exp(input int rc[12], input int n_rd,
                           input int n_wr, input int done_rel,
                           input int base);
      for (int i = 0; i < n_rd; i++)
         rq.push_back('{base + rc[i], ta[i], tb_[i], tt[i],
                        (i / 4) % 2, i / 4});
      for (int i = 0; i < n_wr; i++)
         wq.push_back('{base + rc[i] + P, ta[i], tb_[i]});
      if (done_rel > 0) dq.push_back(base + done_rel);
   endtask

   // caller sits at posedge+1; start is driven in this cycle (rel 0)
   task automatic run(input int rc[12], input int n_rd, input int n_wr,
                      input int done_rel, input int end_rel,
                      input logic [63:0] smap, input int xs,
                      input int rr);
      int base;
      base  = cyc;
      start = 1'b1;
      stall = smap[0];
      reset = 1'b0;
      push_exp(rc, n_rd, n_wr, done_rel, base);
      for (int r = 1; r <= end_rel; r++) begin
         @(posedge clk);
         #1;
         start = (r == xs) || (r == rr);
         stall = smap[r];
         reset = (r == rr);
         if (rr > 0 && r == rr + 1) check_idle("after_reset");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         stall = 1'b0;
         reset = 1'b0;
      end
   endtask

   task automatic drained(input string nm);
      chk({nm, "_rd_left"}, rq.size(), 0);
      chk({nm, "_wr_left"}, wq.size(), 0);
      chk({nm, "_done_left"}, dq.size(), 0);
      chk({nm, "_hold_left"}, hq.size(), 0);
   endtask

   initial begin
      logic [63:0] smap;
      int base;
      int s6;

      smap = '0;
      foreach (sl[i]) smap[sl[i]] = 1'b1;

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset");
      reset  = 1'b0;
      mon_en = 1'b1;
      idle(2);

      // plain run with a start while busy, then back-to-back restart
      run(rc_ns, 12, 12, 19, 19, '0, 5, -1);
      run(rc_ns, 12, 12, 19, 19, '0, -1, -1);
      idle(3);
      drained("restart");

      // stalls in 5 RUN cycles and across every DRAIN
      base = cyc;
      hq.push_back('{base + 2, 2, 3});
      hq.push_back('{base + 3, 2, 3});
      hq.push_back('{base + 10, 1, 3});
      hq.push_back('{base + 17, 1, 5});
      hq.push_back('{base + 18, 1, 5});
      run(rc_st, 12, 12, 24, 24, smap, -1, -1);
      idle(3);
      drained("stall");

      // reset with start during stage 2, after a start while busy
      run(rc_ns, 10, 8, -1, 20, '0, 8, 14);
      idle(3);
      drained("midreset");

      // default size: latency and read count
      start6 = 1'b1;
      s6 = cyc;
      @(posedge clk);
      #1;
      start6 = 1'b0;
      for (int k = 0; k < 400 && n6_done == 0; k++) @(posedge clk);
      #1;
      chk("n64_done_count", n6_done, 1);
      chk("n64_done_latency", d6_cyc - s6, 211);
      chk("n64_rd_count", n6_rd, 192);
      chk("n64_busy_after", int'(busy6), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
